// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic-light phase scheduler family.
package tl_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } phase_t;

  localparam int MAX_APP = 8;
  localparam logic [MAX_APP-1:0] LAMP_NONE = '0;
  localparam logic [MAX_APP-1:0] LAMP_ALL  = '1;

  localparam int DEF_N_APP     = 4;
  localparam int DEF_MIN_GREEN = 3;
  localparam int DEF_MAX_GREEN = 6;
  localparam int DEF_YELLOW_T  = 2;
  localparam int DEF_ALLRED_T  = 1;

  function automatic int lamp_bit(input int idx);
    return 1 << idx;
  endfunction

endpackage

// File: rtl/tl_rr_select.sv
// Combinational round-robin picker: first set bit of pend & mask after cur.
module tl_rr_select #(
  parameter int N_APP = 4,
  parameter int AW    = 2
) (
  input  logic [N_APP-1:0] pend,
  input  logic [AW-1:0]    cur,
  input  logic [N_APP-1:0] mask,
  output logic [AW-1:0]    idx,
  output logic             found
);

  logic [N_APP-1:0] cand;
  logic [AW-1:0]    probe;

  assign cand = pend & mask;

  // Scan the farthest offset first so the nearest candidate is written last.
  always_comb begin
    idx   = cur;
    found = 1'b0;
    probe = cur;
    for (int k = N_APP; k >= 1; k--) begin
      probe = AW'((int'(cur) + k) % N_APP);
      if (cand[probe]) begin
        idx   = probe;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_phase_scheduler.sv
// Intersection phase scheduler: one green shared by N_APP approaches with
// round-robin service, gap/max-out and emergency preempt.
//   state  | meaning
//   ALLRED | clearance, every lamp red; next_app still retargetable
//   GREEN  | cur_app green; exits on preempt, gap-out or max-out
//   YELLOW | cur_app yellow for YELLOW_T cycles, never shortened
module tl_phase_scheduler
  import tl_pkg::*;
#(
  parameter int N_APP     = 4,
  parameter int AW        = 2,
  parameter int TW        = 8,
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 40,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_APP-1:0] req,
  input  logic             preempt,
  input  logic [AW-1:0]    preempt_id,
  output logic [N_APP-1:0] green,
  output logic [N_APP-1:0] yellow,
  output logic [N_APP-1:0] red,
  output logic [AW-1:0]    cur_app,
  output logic             phase_start
);

  localparam logic [TW-1:0] T_SAT = '1;

  phase_t           state;
  logic [TW-1:0]    timer;
  logic [AW-1:0]    next_app;
  logic [N_APP-1:0] pend;

  logic [N_APP-1:0] cur_oh, tgt_oh, green_oh, pend_set;
  logic [AW-1:0]    tgt, rr_idx;
  logic             pre_ok, others;
  logic [TW-1:0]    timer_inc;

  // Out-of-range ids only exist when N_APP is not a power of two.
  assign pre_ok    = preempt && (32'(preempt_id) < 32'(N_APP));
  assign cur_oh    = N_APP'(1) << cur_app;
  assign tgt       = pre_ok ? preempt_id : next_app;
  assign tgt_oh    = N_APP'(1) << tgt;
  assign green_oh  = (state == GREEN) ? cur_oh : '0;
  assign pend_set  = pend | (req & ~green_oh);
  assign timer_inc = (timer == T_SAT) ? timer : timer + TW'(1);

  // found is exactly "some approach other than cur_app is pending".
  tl_rr_select #(.N_APP(N_APP), .AW(AW)) u_rr (
    .pend  (pend),
    .cur   (cur_app),
    .mask  (~cur_oh),
    .idx   (rr_idx),
    .found (others)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ALLRED;
      timer       <= '0;
      cur_app     <= '0;
      next_app    <= '0;
      pend        <= '0;
      phase_start <= 1'b0;
    end else begin
      phase_start <= 1'b0;
      timer       <= timer_inc;
      pend        <= pend_set;
      case (state)
        ALLRED: begin
          if (pre_ok) next_app <= preempt_id;
          if (timer == TW'(ALLRED_T - 1)) begin
            state       <= GREEN;
            timer       <= '0;
            cur_app     <= tgt;
            phase_start <= 1'b1;
            pend        <= pend_set & ~tgt_oh;
          end
        end
        GREEN: begin
          if (pre_ok) begin
            if (preempt_id != cur_app) begin
              state    <= YELLOW;
              timer    <= '0;
              next_app <= preempt_id;
            end
          end else if (others &&
                       ((timer >= TW'(MIN_GREEN - 1) && !req[cur_app]) ||
                        timer >= TW'(MAX_GREEN - 1))) begin
            state    <= YELLOW;
            timer    <= '0;
            next_app <= rr_idx;
          end
        end
        YELLOW: begin
          if (pre_ok) next_app <= preempt_id;
          if (timer == TW'(YELLOW_T - 1)) begin
            state <= ALLRED;
            timer <= '0;
          end
        end
        default: begin
          state <= ALLRED;
          timer <= '0;
        end
      endcase
    end
  end

  always_comb begin
    green  = '0;
    yellow = '0;
    if (state == GREEN)       green  = cur_oh;
    else if (state == YELLOW) yellow = cur_oh;
  end

  assign red = ~(green | yellow);

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Scenario bench for tl_phase_scheduler; expected green owners are queued
// as stimulus is applied and checked on every phase_start.
module tb_tl_phase_scheduler;
  import tl_pkg::*;

  localparam int N  = DEF_N_APP;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          preempt = 1'b0;
  logic [AW-1:0] preempt_id = '0;
  logic [N-1:0]  green, yellow, red;
  logic [AW-1:0] cur_app;
  logic          phase_start;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  tl_phase_scheduler #(
    .N_APP(N), .AW(AW), .TW(8),
    .MIN_GREEN(DEF_MIN_GREEN), .MAX_GREEN(DEF_MAX_GREEN),
    .YELLOW_T(DEF_YELLOW_T), .ALLRED_T(DEF_ALLRED_T)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .preempt(preempt),
    .preempt_id(preempt_id), .green(green), .yellow(yellow), .red(red),
    .cur_app(cur_app), .phase_start(phase_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    int a;
    if (rst && phase_start) begin
      if (exp_q.size() == 0) chk("spurious_start", exp_q.size(), 1);
      else begin
        a = exp_q.pop_front();
        chk("start_app", int'(cur_app), a);
        chk("start_green", int'(green), lamp_bit(a));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(input int i);
    fork
      automatic int k = i;
      begin
        req = req | N'(1 << k);
        @(negedge clk);
        req = req & ~N'(1 << k);
      end
    join_none
  endtask

  task automatic pulse_preempt(input int id);
    fork
      automatic int k = id;
      begin
        preempt = 1'b1;
        preempt_id = AW'(k);
        @(negedge clk);
        preempt = 1'b0;
      end
    join_none
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!phase_start && n < 60);
    chk({tag, "_start_seen"}, int'(phase_start), 1);
  endtask

  task automatic wait_yellow(input string tag);
    int n = 0;
    while (yellow == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_yellow_seen"}, int'(yellow != '0), 1);
  endtask

  task automatic count_yellow(output int n);
    n = 0;
    while (yellow != '0 && n < 60) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_allred(output int n);
    n = 0;
    while (red == '1 && n < 60) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_green(output int n);
    n = 0;
    while (green != '0 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rest_green(input string tag, input int app, input int cycles);
    int g = 0;
    repeat (cycles) begin
      step(1);
      if (int'(green) == lamp_bit(app)) g++;
    end
    chk(tag, g, cycles);
  endtask

  initial begin
    int n;
    #1 rst = 1'b0;
    #2;
    chk("reset_red", int'(red), int'(LAMP_ALL[N-1:0]));
    chk("reset_green", int'(green), 0);
    chk("reset_yellow", int'(yellow), 0);
    chk("reset_ps", int'(phase_start), 0);

    // idle release: app0 green after one clearance cycle, then rests
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(0);
    chk("first_cycle_red", int'(red), int'(LAMP_ALL[N-1:0]));
    wait_start("init");
    step(1);
    chk("ps_one_cycle", int'(phase_start), 0);
    rest_green("rest_app0", 0, 55);

    // gap-out to app2, with req3 arriving during yellow
    pulse_req(2);
    exp_q.push_back(2);
    wait_yellow("gap0");
    pulse_req(3);
    exp_q.push_back(3);
    count_yellow(n); chk("yellow_len", n, DEF_YELLOW_T);
    count_allred(n); chk("allred_len", n, DEF_ALLRED_T);
    count_green(n);  chk("min_green_app2", n, DEF_MIN_GREEN);
    count_yellow(n); chk("yellow_len_app2", n, DEF_YELLOW_T);
    count_allred(n); chk("allred_len_app2", n, DEF_ALLRED_T);
    chk("app3_green", int'(green), lamp_bit(3));

    // max-out with req0 held, round-robin 1 -> 3 -> 0
    req[0] = 1'b1;
    exp_q.push_back(0);
    wait_start("to_app0");
    pulse_req(1);
    pulse_req(3);
    exp_q.push_back(1);
    exp_q.push_back(3);
    exp_q.push_back(0);
    count_green(n); chk("maxout_app0", n, DEF_MAX_GREEN);
    count_yellow(n);
    count_allred(n);
    count_green(n); chk("rr_app1_green", n, DEF_MIN_GREEN);
    count_yellow(n);
    count_allred(n);
    count_green(n); chk("rr_app3_green", n, DEF_MIN_GREEN);
    count_yellow(n);
    count_allred(n);
    req[0] = 1'b0;
    rest_green("rest_app0_after_rr", 0, 20);

    // preempt on the first green cycle overrides MIN_GREEN
    pulse_req(1);
    exp_q.push_back(1);
    wait_start("to_app1");
    preempt = 1'b1;
    preempt_id = 2'd3;
    exp_q.push_back(3);
    step(1);
    chk("preempt_yellow_now", int'(yellow), lamp_bit(1));
    count_yellow(n); chk("preempt_yellow_len", n, DEF_YELLOW_T);
    count_allred(n); chk("preempt_allred_len", n, DEF_ALLRED_T);
    pulse_req(0);
    rest_green("preempt_hold_app3", 3, 30);
    preempt = 1'b0;
    exp_q.push_back(0);
    wait_start("release_to_app0");

    // preempt pulse during yellow retargets; pend1 served afterwards
    step(5);
    pulse_req(1);
    wait_yellow("pre_y");
    pulse_preempt(2);
    exp_q.push_back(2);
    exp_q.push_back(1);
    count_yellow(n); chk("yellow_not_shortened", n, DEF_YELLOW_T);
    count_allred(n);
    count_green(n);  chk("preempted_app2_green", n, DEF_MIN_GREEN);
    count_yellow(n);
    count_allred(n);
    rest_green("rest_app1", 1, 10);

    // async reset mid-green with pend3 outstanding
    preempt = 1'b1;
    preempt_id = 2'd1;
    pulse_req(3);
    step(3);
    #2 rst = 1'b0;
    #1;
    chk("async_red", int'(red), int'(LAMP_ALL[N-1:0]));
    chk("async_green", int'(green), 0);
    chk("async_ps", int'(phase_start), 0);
    preempt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(0);
    wait_start("post_reset");
    rest_green("post_reset_rest", 0, 20);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
